// File: rtl/axis_network_packetizer.sv
// AXI-Stream to NoC packetizer (injection side).
// Each buffered beat is serialised into K = TDataWidth/FlitWidth flits, LSB
// slice first. Network packets start with a header flit (tdest, tid, local
// address) and are cut after MaxPayloadFlits payload flits, with the header
// repeated for the next segment. The VC comes from the latched tid and an
// all-ones tdest marks the packet as broadcast.
module axis_network_packetizer #(
  parameter int NetworkIfAddressId               = 0,
  parameter int NetworkIfAddressIdWidth          = 8,
  parameter int NetworkIfFlitWidth               = 64,
  parameter int NetworkIfFlitTypeWidth           = 2,
  parameter int NetworkIfBroadcastWidth          = 1,
  parameter int NetworkIfVirtualChannelIdWidth   = 2,
  parameter int NetworkIfNumberOfVirtualChannels = 4,
  parameter int AxiStreamTargetIfTDataWidth      = 128,
  parameter int AxiStreamTargetIfTIdWidth        = 4,
  parameter int AxiStreamTargetIfTDestWidth      = 8,
  parameter int MaxPayloadFlits                  = 8
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic                                        s_axis_tvalid_i,
  output logic                                        s_axis_tready_o,
  input  logic [AxiStreamTargetIfTDataWidth-1:0]      s_axis_tdata_i,
  input  logic                                        s_axis_tlast_i,
  input  logic [AxiStreamTargetIfTIdWidth-1:0]        s_axis_tid_i,
  input  logic [AxiStreamTargetIfTDestWidth-1:0]      s_axis_tdest_i,
  output logic                                        network_valid_o,
  input  logic [NetworkIfNumberOfVirtualChannels-1:0] network_ready_i,
  output logic [NetworkIfFlitWidth-1:0]               network_flit_o,
  output logic [NetworkIfFlitTypeWidth-1:0]           network_flit_type_o,
  output logic [NetworkIfBroadcastWidth-1:0]          network_broadcast_o,
  output logic [NetworkIfVirtualChannelIdWidth-1:0]   network_virtual_channel_id_o
);

  localparam int FlitW  = NetworkIfFlitWidth;
  localparam int TypeW  = NetworkIfFlitTypeWidth;
  localparam int VcW    = NetworkIfVirtualChannelIdWidth;
  localparam int TIdW   = AxiStreamTargetIfTIdWidth;
  localparam int TDestW = AxiStreamTargetIfTDestWidth;
  localparam int AddrW  = NetworkIfAddressIdWidth;
  localparam int K      = AxiStreamTargetIfTDataWidth / FlitW;
  localparam int SliceW = (K > 1) ? $clog2(K) : 1;
  localparam int SegW   = (MaxPayloadFlits > 1) ? $clog2(MaxPayloadFlits) : 1;

  localparam logic [0:0] S_HEAD = 1'b0;
  localparam logic [0:0] S_BODY = 1'b1;

  localparam logic [SliceW-1:0] LastSlice = SliceW'(K - 1);
  localparam logic [SegW-1:0]   LastSeg   = SegW'(MaxPayloadFlits - 1);

  localparam logic [TypeW-1:0] T_HEAD = TypeW'(0);
  localparam logic [TypeW-1:0] T_PAY  = TypeW'(1);
  localparam logic [TypeW-1:0] T_TAIL = TypeW'(2);

  logic                          r_en;
  logic                          r_buf_vld;
  logic [K-1:0][FlitW-1:0]       r_data;
  logic                          r_last;
  logic                          r_mid;
  logic [TIdW-1:0]               r_tid;
  logic [TDestW-1:0]             r_tdest;
  logic [0:0]                    r_state;
  logic [SliceW-1:0]             r_slice;
  logic [SegW-1:0]               r_seg_cnt;

  logic [VcW-1:0]   w_vc;
  logic             w_send;
  logic             w_last_slice;
  logic             w_tail;
  logic             w_beat_done;
  logic             w_accept;
  logic             w_bcast;
  logic [FlitW-1:0] w_hdr;

  assign w_vc         = r_tid[VcW-1:0];
  assign w_send       = r_buf_vld & network_ready_i[w_vc];
  assign w_last_slice = (r_slice == LastSlice);
  assign w_tail       = (r_state == S_BODY) &
                        ((w_last_slice & r_last) | (r_seg_cnt == LastSeg));
  assign w_beat_done  = w_send & (r_state == S_BODY) & w_last_slice;
  assign w_bcast      = &r_tdest;

  // Ready when the buffer is free or its last slice leaves this cycle, so a
  // new beat can follow back-to-back; gated until the first edge after reset.
  assign s_axis_tready_o = r_en & (~r_buf_vld | w_beat_done);
  assign w_accept        = s_axis_tvalid_i & s_axis_tready_o;
  assign network_valid_o = w_send;

  // Header flit: tdest in the LSBs, then tid, then source address, zero-padded.
  always_comb begin
    w_hdr = '0;
    w_hdr[TDestW-1:0]             = r_tdest;
    w_hdr[TDestW +: TIdW]         = r_tid;
    w_hdr[TDestW+TIdW +: AddrW]   = AddrW'(NetworkIfAddressId);
  end

  // Flit outputs are zero while nothing is pending, and held during a stall.
  always_comb begin
    network_flit_o               = '0;
    network_flit_type_o          = T_HEAD;
    network_broadcast_o          = '0;
    network_virtual_channel_id_o = '0;
    if (r_buf_vld) begin
      network_virtual_channel_id_o = w_vc;
      network_broadcast_o          = {NetworkIfBroadcastWidth{w_bcast}};
      if (r_state == S_HEAD) begin
        network_flit_o      = w_hdr;
        network_flit_type_o = T_HEAD;
      end else begin
        network_flit_o      = r_data[r_slice];
        network_flit_type_o = w_tail ? T_TAIL : T_PAY;
      end
    end
  end

  // Input enable rises one edge after reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_en <= 1'b0;
    else         r_en <= 1'b1;
  end

  // One-beat buffer: load on accept, free when its last slice is sent.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_buf_vld <= 1'b0;
      r_data    <= '0;
      r_last    <= 1'b0;
    end else if (w_accept) begin
      r_buf_vld <= 1'b1;
      r_data    <= s_axis_tdata_i;
      r_last    <= s_axis_tlast_i;
    end else if (w_beat_done) begin
      r_buf_vld <= 1'b0;
    end
  end

  // tid/tdest are captured only on the first beat of a stream packet.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mid   <= 1'b0;
      r_tid   <= '0;
      r_tdest <= '0;
    end else if (w_accept) begin
      r_mid <= ~s_axis_tlast_i;
      if (!r_mid) begin
        r_tid   <= s_axis_tid_i;
        r_tdest <= s_axis_tdest_i;
      end
    end
  end

  // Header/body sequencing with slice and segment counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_HEAD;
      r_slice   <= '0;
      r_seg_cnt <= '0;
    end else if (w_send) begin
      if (r_state == S_HEAD) begin
        r_state   <= S_BODY;
        r_seg_cnt <= '0;
      end else begin
        r_slice <= w_last_slice ? '0 : r_slice + 1'b1;
        if (w_tail) begin
          r_state   <= S_HEAD;
          r_seg_cnt <= '0;
        end else begin
          r_seg_cnt <= r_seg_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_network_packetizer.sv
// Directed bench for axis_network_packetizer with default parameters
// (K=2 slices per beat, 8 payload flits per network packet).
module tb_axis_network_packetizer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         tvalid;
  logic         tready;
  logic [127:0] tdata;
  logic         tlast;
  logic [3:0]   tid;
  logic [7:0]   tdest;
  logic         nvalid;
  logic [3:0]   nready;
  logic [63:0]  flit;
  logic [1:0]   ftype;
  logic [0:0]   bc;
  logic [1:0]   vc;

  int errors = 0;
  int checks = 0;
  int gpf    = 0;

  // beat stimulus for the current run
  logic [127:0] bd[$];
  bit           bl[$];
  logic [3:0]   btid[$];
  logic [7:0]   bdst[$];

  axis_network_packetizer dut (
    .clk_i                        (clk),
    .rst_ni                       (rst_n),
    .s_axis_tvalid_i              (tvalid),
    .s_axis_tready_o              (tready),
    .s_axis_tdata_i               (tdata),
    .s_axis_tlast_i               (tlast),
    .s_axis_tid_i                 (tid),
    .s_axis_tdest_i               (tdest),
    .network_valid_o              (nvalid),
    .network_ready_i              (nready),
    .network_flit_o               (flit),
    .network_flit_type_o          (ftype),
    .network_broadcast_o          (bc),
    .network_virtual_channel_id_o (vc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string what,
                     input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s: observed %0h, expected %0h", tag, what, obs, exp);
    end
  endtask

  task automatic drive(input int bi);
    if (bi < bd.size()) begin
      tvalid = 1'b1;
      tdata  = bd[bi];
      tlast  = bl[bi];
      tid    = btid[bi];
      tdest  = bdst[bi];
    end else begin
      tvalid = 1'b0;
      tlast  = 1'b0;
    end
  endtask

  // np packets of nb beats each, sent back to back. Packet p uses tdest+p;
  // continuation beats carry inverted tid/tdest, which must be ignored.
  // stall_at >= 0 holds the active VC not-ready for 5 cycles before that flit.
  task automatic run(input string tag, input int np, input int nb,
                     input logic [3:0] t_id, input logic [7:0] t_dest,
                     input int stall_at);
    logic [63:0] ef[$];
    int          et[$];
    bit          er[$];
    bit          ebc[$];
    logic [63:0] pl[$];
    logic [63:0] hdr, lo, hi;
    logic [7:0]  tp;
    int          seg, bi;
    bit          tl, acc;
    bd.delete(); bl.delete(); btid.delete(); bdst.delete();
    for (int p = 0; p < np; p++) begin
      tp  = t_dest + 8'(p);
      hdr = '0;
      hdr[7:0]   = tp;
      hdr[11:8]  = t_id;
      hdr[19:12] = 8'h00;
      pl.delete();
      for (int b = 0; b < nb; b++) begin
        lo = 64'hC0DE_0000_0000_0000 | 64'(gpf);
        hi = 64'hC0DE_0000_0000_0000 | 64'(gpf + 1);
        gpf += 2;
        bd.push_back({hi, lo});
        bl.push_back(b == nb - 1);
        btid.push_back((b == 0) ? t_id : ~t_id);
        bdst.push_back((b == 0) ? tp : ~tp);
        pl.push_back(lo);
        pl.push_back(hi);
      end
      ef.push_back(hdr); et.push_back(0); er.push_back(1'b0); ebc.push_back(tp == 8'hFF);
      seg = 0;
      for (int j = 0; j < 2 * nb; j++) begin
        tl = (j == 2 * nb - 1) || (seg == 7);
        ef.push_back(pl[j]); et.push_back(tl ? 2 : 1);
        er.push_back(j % 2 == 1); ebc.push_back(tp == 8'hFF);
        if (tl && j != 2 * nb - 1) begin
          ef.push_back(hdr); et.push_back(0); er.push_back(1'b0); ebc.push_back(tp == 8'hFF);
          seg = 0;
        end else begin
          seg++;
        end
      end
    end
    // first beat goes into the idle buffer
    bi = 0;
    @(negedge clk);
    nready = 4'hF;
    drive(bi);
    #1;
    chk(tag, "idle_ready", tready, 1'b1);
    chk(tag, "idle_valid", nvalid, 1'b0);
    acc = tvalid & tready;
    @(posedge clk);
    if (acc) bi++;
    for (int c = 0; c < ef.size(); c++) begin
      if (c == stall_at) begin
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          nready = ~(4'(1) << t_id[1:0]);
          drive(bi);
          #1;
          chk(tag, "stall_valid", nvalid, 1'b0);
          chk(tag, "stall_flit", flit, ef[c]);
          chk(tag, "stall_type", ftype, et[c]);
          chk(tag, "stall_ready", tready, 1'b0);
          @(posedge clk);
        end
      end
      @(negedge clk);
      nready = 4'hF;
      drive(bi);
      #1;
      chk(tag, "valid", nvalid, 1'b1);
      chk(tag, "type", ftype, et[c]);
      chk(tag, "flit", flit, ef[c]);
      chk(tag, "vc", vc, t_id[1:0]);
      chk(tag, "bcast", bc, ebc[c]);
      chk(tag, "tready", tready, er[c]);
      acc = tvalid & tready;
      @(posedge clk);
      if (acc) bi++;
    end
    @(negedge clk);
    tvalid = 1'b0;
    #1;
    chk(tag, "beats", bi, bd.size());
    chk(tag, "drained", nvalid, 1'b0);
  endtask

  initial begin
    rst_n  = 1'b0;
    tvalid = 1'b0;
    tdata  = '0;
    tlast  = 1'b0;
    tid    = '0;
    tdest  = '0;
    nready = 4'hF;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst", "valid", nvalid, 1'b0);
    chk("rst", "tready", tready, 1'b0);
    chk("rst", "flit", flit, 64'h0);
    chk("rst", "type", ftype, 2'd0);
    chk("rst", "bcast", bc, 1'b0);
    chk("rst", "vc", vc, 2'd0);
    rst_n = 1'b1;
    #1;
    chk("rst", "tready_before_edge", tready, 1'b0);
    @(posedge clk);

    // single beat, K=2: H(0x105), P, T on VC 1
    run("single", 1, 1, 4'd1, 8'h05, -1);
    // 5 beats: H, P x7, T, H, P, T with identical headers
    run("segment", 1, 5, 4'd2, 8'h11, -1);
    // stall on VC 1 mid-body (ready = 4'b1101)
    run("stall", 1, 2, 4'd1, 8'h33, 2);
    // broadcast then unicast
    run("bcast", 1, 1, 4'd0, 8'hFF, -1);
    run("ucast", 1, 1, 4'd0, 8'h03, -1);
    // two back-to-back one-beat packets: six flits in six cycles
    run("b2b", 2, 1, 4'd3, 8'h40, -1);

    // reset after header and one payload flit
    @(negedge clk);
    tvalid = 1'b1;
    tdata  = {64'hDEAD_0000_0000_0002, 64'hDEAD_0000_0000_0001};
    tlast  = 1'b0;
    tid    = 4'd1;
    tdest  = 8'h22;
    nready = 4'hF;
    #1;
    chk("midrst", "accept", tready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    tvalid = 1'b0;
    #1;
    chk("midrst", "hdr_type", ftype, 2'd0);
    chk("midrst", "hdr_flit", flit, 64'h0000_0000_0000_0122);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("midrst", "pay_type", ftype, 2'd1);
    chk("midrst", "pay_flit", flit, 64'hDEAD_0000_0000_0001);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst", "valid", nvalid, 1'b0);
    chk("midrst", "tready", tready, 1'b0);
    chk("midrst", "flit", flit, 64'h0);
    chk("midrst", "type", ftype, 2'd0);
    chk("midrst", "bcast", bc, 1'b0);
    chk("midrst", "vc", vc, 2'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst", "tready_before_edge", tready, 1'b0);
    @(posedge clk);
    run("after_rst", 1, 1, 4'd2, 8'h07, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
